// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: field width, default polynomial and arithmetic helpers.
package gf_pkg;

    localparam int unsigned GF_W = 8;
    // Low 8 bits of x^8+x^4+x^3+x^2+1; the x^8 term is implicit.
    localparam logic [GF_W-1:0] DEFAULT_POLY = 8'h1D;

    // Carry-less multiply of a by b, reduced modulo {1,poly} (shift-and-add form).
    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                               input logic [GF_W-1:0] b,
                                               input logic [GF_W-1:0] poly);
        logic [GF_W-1:0] acc;
        logic [GF_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < GF_W; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[GF_W-1] ? ({sh[GF_W-2:0], 1'b0} ^ poly) : {sh[GF_W-2:0], 1'b0};
        end
        return acc;
    endfunction

    // alpha^(2^i) with alpha = 0x02, obtained by squaring alpha i times.
    function automatic logic [GF_W-1:0] gf_sq_const(input int unsigned i,
                                                    input logic [GF_W-1:0] poly);
        logic [GF_W-1:0] c;
        c = 8'h02;
        for (int unsigned k = 0; k < i; k++) begin
            c = gf_mul(c, c, poly);
        end
        return c;
    endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^8) multiplier; thin wrapper around the package function.
module gf_mul
    import gf_pkg::*;
#(
    parameter logic [GF_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    output logic [GF_W-1:0] o_p
);

    // Product of the two field elements.
    always_comb begin
        o_p = gf_pkg::gf_mul(i_a, i_b, POLY);
    end

endmodule

// File: rtl/gf_exp.sv
// GF(2^8) antilog unit: out = alpha^in, one registered output stage.
// Each exponent bit selects either alpha^(2^i) or 1; the eight operands are
// combined by a balanced tree of seven multipliers (three levels deep).
module gf_exp
    import gf_pkg::*;
#(
    parameter logic [GF_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [GF_W-1:0] in,
    output logic            out_valid,
    output logic [GF_W-1:0] out
);

    logic [GF_W-1:0] w_op [GF_W];
    logic [GF_W-1:0] w_l1 [4];
    logic [GF_W-1:0] w_l2 [2];
    logic [GF_W-1:0] w_prod;
    logic [GF_W-1:0] r_out;
    logic            r_valid;

    // Per-bit operand select; constants derived from POLY at elaboration.
    for (genvar g = 0; g < GF_W; g++) begin : g_stage
        localparam logic [GF_W-1:0] C = gf_sq_const(g, POLY);
        assign w_op[g] = in[g] ? C : 8'h01;
    end

    // Level 1: pairwise products of adjacent operands.
    for (genvar g = 0; g < 4; g++) begin : g_l1
        gf_mul #(.POLY(POLY)) u_mul (
            .i_a (w_op[2*g]),
            .i_b (w_op[2*g+1]),
            .o_p (w_l1[g])
        );
    end

    // Level 2.
    for (genvar g = 0; g < 2; g++) begin : g_l2
        gf_mul #(.POLY(POLY)) u_mul (
            .i_a (w_l1[2*g]),
            .i_b (w_l1[2*g+1]),
            .o_p (w_l2[g])
        );
    end

    // Level 3: final product.
    gf_mul #(.POLY(POLY)) u_mul_root (
        .i_a (w_l2[0]),
        .i_b (w_l2[1]),
        .o_p (w_prod)
    );

    // Output register: result loads only on valid input, valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_out <= w_prod;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_gf_exp.sv
// Directed self-checking bench for gf_exp (default polynomial 0x11D).
module tb_gf_exp;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in;
    logic       out_valid;
    logic [7:0] out;

    int n_pass = 0;
    int n_total = 0;

    gf_exp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference multiply-by-alpha for the 0x11D field.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
    endfunction

    // Drive one valid exponent at a falling edge, check the result one cycle later.
    task automatic one(input string tag, input logic [7:0] e, input logic [7:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in       = e;
        @(negedge clk);
        in_valid = 1'b0;
        chk(tag, out, exp);
        chk({tag, "_v"}, {7'b0, out_valid}, 8'h01);
    endtask

    logic [7:0] prev;
    bit         seen [256];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        #2;
        chk("rst_out", out, 8'h00);
        chk("rst_valid", {7'b0, out_valid}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_hold_out", out, 8'h00);

        // Basic values and boundaries.
        one("e00", 8'h00, 8'h01);
        one("e01", 8'h01, 8'h02);
        one("e07", 8'h07, 8'h80);
        one("e08", 8'h08, 8'h1D);
        one("e19", 8'h19, 8'h03);
        one("eDF", 8'hDF, 8'h09);
        one("eFE", 8'hFE, 8'h8E);
        one("eFF", 8'hFF, 8'h01);

        // Hold: result from e=08 must persist while in toggles with in_valid low.
        one("h_pre", 8'h08, 8'h1D);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in = 8'h55 ^ 8'(k * 37);
            @(negedge clk);
            chk("hold_out", out, 8'h1D);
            chk("hold_valid", {7'b0, out_valid}, 8'h00);
        end

        // Streaming 08/10 back-to-back, no bubbles.
        @(negedge clk);
        in_valid = 1'b1;
        in       = 8'h08;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("strm_out", out, (k % 2 == 0) ? 8'h1D : 8'h4C);
            chk("strm_valid", {7'b0, out_valid}, 8'h01);
            in = (k % 2 == 0) ? 8'h10 : 8'h08;
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Exhaustive back-to-back sweep.
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        prev = 8'h00;
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("sw_valid", {7'b0, out_valid}, 8'h01);
                if (k == 1) chk("sw_first", out, 8'h01);
                else        chk("sw_step", out, xtime(prev));
                if (k <= 255) begin
                    chk("sw_dup", {7'b0, seen[out]}, 8'h00);
                    seen[out] = 1'b1;
                    n_total++;
                    assert (out !== 8'h00) n_pass++;
                    else $error("FAIL sw_zero: observed %h expected nonzero", out);
                end
                if (k == 256) chk("sw_wrap", out, 8'h01);
                prev = out;
            end
            if (k < 256) begin
                in_valid = 1'b1;
                in       = 8'(k);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset mid-run: clears immediately and drops the in-flight result.
        @(negedge clk);
        in_valid = 1'b1;
        in       = 8'h08;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 8'h00);
        chk("mid_rst_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop_out", out, 8'h00);
        chk("drop_valid", {7'b0, out_valid}, 8'h00);
        one("post_rst", 8'h10, 8'h4C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
